rtype_alu_sequencer: RTL and testbench

Multi-cycle controller that sequences the R-type datapath: it accepts one 32-bit instruction through a valid/ready handshake, drives the register-file read addresses, selects the ALU operation, captures the ALU result and zero flag, and issues a single register-file write. It sits between the instruction source and the shared register file / ALU pair, and owns the only write port into the register file for R-type instructions.

---
 rtl/rtype_pkg.sv | 51 +++++
 rtl/rtype_funct_decode.sv | 34 +++
 rtl/rtype_alu_sequencer.sv | 129 ++++++++++++
 tb/tb_rtype_alu_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rtype_pkg.sv
`default_nettype none
//============================================================================
// Module      : rtype_pkg
// Description : Shared constants and types for the R-type ALU sequencer:
//               funct codes, ALU control codes, FSM state encoding and
//               instruction field positions.
// Revision    : 1.0 - initial release
//============================================================================
package rtype_pkg;

    // Supported funct codes
    localparam logic [5:0] c_FUNCT_ADD = 6'h20;
    localparam logic [5:0] c_FUNCT_SUB = 6'h22;
    localparam logic [5:0] c_FUNCT_AND = 6'h24;
    localparam logic [5:0] c_FUNCT_OR  = 6'h25;
    localparam logic [5:0] c_FUNCT_SLT = 6'h2A;

    // ALU control encoding understood by the shared ALU
    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;

    // Only op == 0 selects the R-type format
    localparam logic [5:0] c_OP_RTYPE = 6'h00;

    // Instruction field positions
    localparam int c_OP_MSB    = 31;
    localparam int c_OP_LSB    = 26;
    localparam int c_RS_MSB    = 25;
    localparam int c_RS_LSB    = 21;
    localparam int c_RT_MSB    = 20;
    localparam int c_RT_LSB    = 16;
    localparam int c_RD_MSB    = 15;
    localparam int c_RD_LSB    = 11;
    localparam int c_SHAMT_MSB = 10;
    localparam int c_SHAMT_LSB = 6;
    localparam int c_FUNCT_MSB = 5;
    localparam int c_FUNCT_LSB = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage : rtype_pkg
`default_nettype wire

// File: rtl/rtype_funct_decode.sv
`default_nettype none
//============================================================================
// Module      : rtype_funct_decode
// Description : Combinational op/funct decoder producing the ALU control
//               code and a legal-instruction flag.
// Revision    : 1.0 - initial release
//============================================================================
module rtype_funct_decode
    import rtype_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alu_code,
    output logic       legal
);

    // Map funct to ALU control; anything unknown or non-R-type is illegal
    always_comb begin
        alu_code = c_ALU_AND;
        legal    = 1'b0;
        if (op == c_OP_RTYPE) begin
            case (funct)
                c_FUNCT_ADD: begin alu_code = c_ALU_ADD; legal = 1'b1; end
                c_FUNCT_SUB: begin alu_code = c_ALU_SUB; legal = 1'b1; end
                c_FUNCT_AND: begin alu_code = c_ALU_AND; legal = 1'b1; end
                c_FUNCT_OR:  begin alu_code = c_ALU_OR;  legal = 1'b1; end
                c_FUNCT_SLT: begin alu_code = c_ALU_SLT; legal = 1'b1; end
                default:     begin alu_code = c_ALU_AND; legal = 1'b0; end
            endcase
        end
    end

endmodule : rtype_funct_decode
`default_nettype wire

// File: rtl/rtype_alu_sequencer.sv
`default_nettype none
//============================================================================
// Module      : rtype_alu_sequencer
// Description : Four-state controller sequencing one R-type instruction
//               through register read, ALU execute and register write-back.
// Revision    : 1.0 - initial release
//============================================================================
module rtype_alu_sequencer
    import rtype_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [4:0]       RA1,
    output logic [4:0]       RA2,
    output logic [3:0]       Op_Alu,
    input  logic [31:0]      Res,
    input  logic             ZF,
    output logic [4:0]       WA,
    output logic [31:0]      WD,
    output logic             RegWrite,
    output logic             ZF_q,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_instr_q;
    logic [31:0]      r_res_q;
    logic             r_zf_q;
    logic [4:0]       r_ra1;
    logic [4:0]       r_ra2;
    logic [4:0]       r_wa;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       w_alu_code;
    logic             w_legal;
    logic             w_accept;
    logic             w_rd_nonzero;
    logic             w_unused_shamt;

    assign w_accept       = (r_state == S_IDLE) && instr_valid;
    assign w_rd_nonzero   = |r_instr_q[c_RD_MSB:c_RD_LSB];
    // shamt is carried in instr_q but plays no part in any supported op
    assign w_unused_shamt = ^r_instr_q[c_SHAMT_MSB:c_SHAMT_LSB];

    rtype_funct_decode u_decode (
        .op       (r_instr_q[c_OP_MSB:c_OP_LSB]),
        .funct    (r_instr_q[c_FUNCT_MSB:c_FUNCT_LSB]),
        .alu_code (w_alu_code),
        .legal    (w_legal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: illegal instructions short-circuit back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (instr_valid) w_next = S_READ;
            S_READ:  w_next = w_legal ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Instruction latch and read addresses; addresses load on accept so they
    // are valid throughout READ/EXEC and simply hold afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_q <= 32'd0;
            r_ra1     <= 5'd0;
            r_ra2     <= 5'd0;
        end else if (w_accept) begin
            r_instr_q <= instr;
            r_ra1     <= instr[c_RS_MSB:c_RS_LSB];
            r_ra2     <= instr[c_RT_MSB:c_RT_LSB];
        end
    end

    // Capture ALU result, zero flag and destination at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_q <= 32'd0;
            r_zf_q  <= 1'b0;
            r_wa    <= 5'd0;
        end else if (r_state == S_EXEC) begin
            r_res_q <= Res;
            r_zf_q  <= ZF;
            r_wa    <= r_instr_q[c_RD_MSB:c_RD_LSB];
        end
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_WB) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign RA1         = r_ra1;
    assign RA2         = r_ra2;
    assign Op_Alu      = (r_state == S_EXEC) ? w_alu_code : c_ALU_AND;
    assign WA          = r_wa;
    assign WD          = r_res_q;
    assign RegWrite    = (r_state == S_WB) && w_rd_nonzero;
    assign done        = (r_state == S_WB);
    assign illegal     = (r_state == S_READ) && !w_legal;
    assign ZF_q        = r_zf_q;
    assign retired_cnt = r_cnt;

endmodule : rtype_alu_sequencer
`default_nettype wire

// File: tb/tb_rtype_alu_sequencer.sv
`default_nettype none
//============================================================================
// Module      : tb_rtype_alu_sequencer
// Description : Directed self-checking bench for rtype_alu_sequencer. A
//               second instance with a 4-bit counter exercises wrap-around.
// Revision    : 1.0 - initial release
//============================================================================
module tb_rtype_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] Res;
    logic        ZF;

    logic        instr_ready, instr_ready4;
    logic [4:0]  RA1, RA2, RA1_4, RA2_4;
    logic [3:0]  Op_Alu, Op_Alu4;
    logic [4:0]  WA, WA4;
    logic [31:0] WD, WD4;
    logic        RegWrite, RegWrite4;
    logic        ZF_q, ZF_q4;
    logic        done, done4;
    logic        illegal, illegal4;
    logic [15:0] retired_cnt;
    logic [3:0]  retired_cnt4;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    logic exp_zf = 1'b0;

    rtype_alu_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .RA1(RA1), .RA2(RA2), .Op_Alu(Op_Alu),
        .Res(Res), .ZF(ZF), .WA(WA), .WD(WD), .RegWrite(RegWrite),
        .ZF_q(ZF_q), .done(done), .illegal(illegal), .retired_cnt(retired_cnt)
    );

    rtype_alu_sequencer #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready4), .RA1(RA1_4), .RA2(RA2_4), .Op_Alu(Op_Alu4),
        .Res(Res), .ZF(ZF), .WA(WA4), .WD(WD4), .RegWrite(RegWrite4),
        .ZF_q(ZF_q4), .done(done4), .illegal(illegal4), .retired_cnt(retired_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check_eq({tag, "_cnt"},  {16'd0, retired_cnt}, exp_cnt % 65536);
        check_eq({tag, "_cnt4"}, {28'd0, retired_cnt4}, exp_cnt % 16);
    endtask

    // Issue one instruction from IDLE and check every cycle through its return to IDLE
    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [31:0] res,
                             input logic legal, input logic [3:0] exp_op);
        check_eq({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        Res         = res;
        ZF          = (res == 32'd0);
        tick();  // READ
        instr_valid = 1'b0;
        check_eq({tag, "_rd_ra1"}, {27'd0, RA1}, {27'd0, ins[25:21]});
        check_eq({tag, "_rd_ra2"}, {27'd0, RA2}, {27'd0, ins[20:16]});
        check_eq({tag, "_rd_op"}, {28'd0, Op_Alu}, 32'd0);
        check_eq({tag, "_rd_ill"}, {31'd0, illegal}, {31'd0, !legal});
        check_eq({tag, "_rd_ctl"}, {29'd0, instr_ready, RegWrite, done}, 32'd0);
        check_eq({tag, "_rd_zfq"}, {31'd0, ZF_q}, {31'd0, exp_zf});
        if (!legal) begin
            tick();  // back in IDLE
            check_eq({tag, "_ret_ready"}, {31'd0, instr_ready}, 32'd1);
            check_eq({tag, "_ret_ctl"}, {29'd0, illegal, RegWrite, done}, 32'd0);
            check_eq({tag, "_ret_zfq"}, {31'd0, ZF_q}, {31'd0, exp_zf});
            check_cnt({tag, "_ret"});
            return;
        end
        tick();  // EXEC
        check_eq({tag, "_ex_op"}, {28'd0, Op_Alu}, {28'd0, exp_op});
        check_eq({tag, "_ex_ra1"}, {27'd0, RA1}, {27'd0, ins[25:21]});
        check_eq({tag, "_ex_ctl"}, {29'd0, illegal, RegWrite, done}, 32'd0);
        tick();  // WB
        exp_cnt++;
        exp_zf = (res == 32'd0);
        check_eq({tag, "_wb_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_wb_we"}, {31'd0, RegWrite}, {31'd0, (ins[15:11] != 5'd0)});
        check_eq({tag, "_wb_wa"}, {27'd0, WA}, {27'd0, ins[15:11]});
        check_eq({tag, "_wb_wd"}, WD, res);
        check_eq({tag, "_wb_zfq"}, {31'd0, ZF_q}, {31'd0, exp_zf});
        check_eq({tag, "_wb_op"}, {28'd0, Op_Alu}, 32'd0);
        check_eq({tag, "_wb_ill"}, {31'd0, illegal}, 32'd0);
        tick();  // IDLE
        check_eq({tag, "_id_ctl"}, {29'd0, instr_ready, RegWrite, done}, 32'd4);
        check_eq({tag, "_id_wd"}, WD, res);
        check_cnt({tag, "_id"});
    endtask

    int acc, dn, rw;

    initial begin
        rst_n       = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        Res         = 32'd0;
        ZF          = 1'b0;
        tick();
        tick();
        // Reset values
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst_addr", {17'd0, RA1, RA2, WA}, 32'd0);
        check_eq("rst_op", {28'd0, Op_Alu}, 32'd0);
        check_eq("rst_wd", WD, 32'd0);
        check_eq("rst_ctl", {28'd0, RegWrite, ZF_q, done, illegal}, 32'd0);
        check_cnt("rst");
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_ready", {31'd0, instr_ready}, 32'd1);

        // ADD $3,$1,$2 / SUB $5,$6,$7 (zero) / illegal jr / SLT / AND / OR+shamt / lw
        run_instr("add",  32'h00221820, 32'h00000007, 1'b1, 4'b0010);
        run_instr("sub",  32'h00C72822, 32'h00000000, 1'b1, 4'b0110);
        run_instr("jr",   32'h00221808, 32'h12345678, 1'b0, 4'b0000);
        run_instr("slt",  32'h012A402A, 32'h00000001, 1'b1, 4'b0111);
        run_instr("and",  32'h018D5824, 32'hA5A50F0F, 1'b1, 4'b0000);
        run_instr("or",   32'h03DDF965, 32'hFFFF00FF, 1'b1, 4'b0001);
        run_instr("lw",   32'h8C221820, 32'h00000000, 1'b0, 4'b0000);

        // Reset asserted mid-EXEC of an ADD
        instr       = 32'h00221820;
        Res         = 32'h00000007;
        ZF          = 1'b0;
        instr_valid = 1'b1;
        tick();  // READ
        instr_valid = 1'b0;
        tick();  // EXEC
        check_eq("mid_ex_op", {28'd0, Op_Alu}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("mid_rst_addr", {17'd0, RA1, RA2, WA}, 32'd0);
        check_eq("mid_rst_wd", WD, 32'd0);
        check_eq("mid_rst_ctl", {27'd0, Op_Alu == 4'd0 ? 1'b0 : 1'b1, RegWrite, ZF_q, done, illegal}, 32'd0);
        exp_cnt = 0;
        exp_zf  = 1'b0;
        check_cnt("mid_rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("mid_rst_we", {30'd0, RegWrite, done}, 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rel_ctl", {29'd0, instr_ready, RegWrite, done}, 32'd4);
        end

        // rd=0 ADD with instr_valid held high: one accept per 4 cycles, no writes
        instr       = 32'h00220020;
        Res         = 32'h0000002A;
        ZF          = 1'b0;
        instr_valid = 1'b1;
        acc = 0; dn = 0; rw = 0;
        for (int i = 0; i < 12; i++) begin
            if (instr_ready) acc++;
            if (done) dn++;
            if (RegWrite) rw++;
            tick();
        end
        instr_valid = 1'b0;
        exp_cnt += 3;
        check_eq("hold_accepts", acc, 32'd3);
        check_eq("hold_done", dn, 32'd3);
        check_eq("hold_regwrite", rw, 32'd0);
        check_eq("hold_ready", {31'd0, instr_ready}, 32'd1);
        check_cnt("hold");

        // Run legal ADDs until the 4-bit counter passes 15 -> 0
        while (exp_cnt < 16) begin
            run_instr("wrap", 32'h00221820, exp_cnt + 32'd100, 1'b1, 4'b0010);
        end
        check_eq("wrap_cnt4", {28'd0, retired_cnt4}, 32'd0);
        check_eq("wrap_cnt16", {16'd0, retired_cnt}, 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rtype_alu_sequencer
`default_nettype wire
